// File: rtl/cam_frame_writer_if.sv
// Camera-to-frame-buffer bundle: OV7670-style pixel stream in, buffer write
// port and frame status out. The writer takes the slave side; whatever
// drives the camera and watches the buffer port takes the master side.
interface cam_frame_writer_if #(
  parameter int ADDR_W = 17
);
  logic              capture_en;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
  logic              frame_we;
  logic [ADDR_W-1:0] frame_addr;
  logic [11:0]       frame_wdata;
  logic              frame_done;
  logic              frame_ok;
  logic              busy;

  modport master (
    output capture_en, cam_vsync, cam_href, cam_data,
    input  frame_we, frame_addr, frame_wdata, frame_done, frame_ok, busy
  );

  modport slave (
    input  capture_en, cam_vsync, cam_href, cam_data,
    output frame_we, frame_addr, frame_wdata, frame_done, frame_ok, busy
  );
endinterface

// File: rtl/cam_frame_writer.sv
// Camera-side frame writer: pairs RGB565 bytes (high byte first) from an
// OV7670-style stream, converts each pixel to RGB444 and writes it to the
// linear frame buffer at row*H_ACTIVE+col. A frame runs from a VSYNC fall
// to the following VSYNC rise and is only captured while capture_en is set.
module cam_frame_writer #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input logic               clk,
  input logic               rst_n,
  cam_frame_writer_if.slave bus
);

  // Counters need one extra code so they can sit at their saturation value.
  localparam int CW = $clog2(H_ACTIVE + 1);
  localparam int RW = $clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0]     COL_MAX   = CW'(H_ACTIVE);
  localparam logic [RW-1:0]     ROW_MAX   = RW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

  state_t            state_reg;
  logic              vsync_q;
  logic              href_q;
  logic              phase_reg;
  logic [7:0]        hi_reg;
  logic [CW-1:0]     col_reg;
  logic [RW-1:0]     row_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic              line_err_reg;
  logic              frame_we_reg;
  logic [ADDR_W-1:0] frame_addr_reg;
  logic [11:0]       frame_wdata_reg;
  logic              frame_done_reg;
  logic              frame_ok_reg;
  logic              busy_reg;

  logic              vs_fall;
  logic              vs_rise;
  logic              href_fall;
  logic              pix_in_range;
  logic [11:0]       pixel_rgb444;
  logic [RW-1:0]     row_after_line;
  logic              err_after_line;
  logic [RW-1:0]     row_at_end;
  logic              err_at_end;

  assign vs_fall   = vsync_q & ~bus.cam_vsync;
  assign vs_rise   = ~vsync_q & bus.cam_vsync;
  assign href_fall = href_q & ~bus.cam_href;

  assign pix_in_range = (col_reg < COL_MAX) && (row_reg < ROW_MAX);

  // RGB565 {hi,lo} -> RGB444: keep the top four bits of each channel.
  assign pixel_rgb444 = {hi_reg[7:4], hi_reg[2:0], bus.cam_data[7], bus.cam_data[4:1]};

  // Line-end bookkeeping, also used so that a VSYNC rise coinciding with the
  // HREF fall judges the frame on the already-updated row count.
  always_comb begin
    row_after_line = (row_reg < ROW_MAX) ? row_reg + RW'(1) : row_reg;
    err_after_line = line_err_reg | (col_reg != COL_MAX);
    row_at_end     = href_fall ? row_after_line : row_reg;
    err_at_end     = href_fall ? err_after_line : line_err_reg;
  end

  // Frame FSM, byte pairing, address generation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      vsync_q         <= 1'b0;
      href_q          <= 1'b0;
      phase_reg       <= 1'b0;
      hi_reg          <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      row_base_reg    <= '0;
      line_err_reg    <= 1'b0;
      frame_we_reg    <= 1'b0;
      frame_addr_reg  <= '0;
      frame_wdata_reg <= '0;
      frame_done_reg  <= 1'b0;
      frame_ok_reg    <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      vsync_q        <= bus.cam_vsync;
      href_q         <= bus.cam_href;
      frame_we_reg   <= 1'b0;
      frame_done_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          phase_reg <= 1'b0;
          if (bus.capture_en) begin
            state_reg <= SYNC;
            busy_reg  <= 1'b1;
          end
        end

        SYNC: begin
          phase_reg <= 1'b0;
          if (vs_fall) begin
            state_reg    <= ACTIVE;
            col_reg      <= '0;
            row_reg      <= '0;
            row_base_reg <= '0;
            line_err_reg <= 1'b0;
          end else if (!bus.capture_en) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end

        ACTIVE: begin
          if (bus.cam_href) begin
            if (!phase_reg) begin
              hi_reg    <= bus.cam_data;
              phase_reg <= 1'b1;
            end else begin
              phase_reg <= 1'b0;
              if (pix_in_range) begin
                frame_we_reg    <= 1'b1;
                frame_addr_reg  <= row_base_reg + ADDR_W'(col_reg);
                frame_wdata_reg <= pixel_rgb444;
              end else begin
                // A dropped pixel means the line or frame was too long, so
                // the frame is not a clean capture.
                line_err_reg <= 1'b1;
              end
              if (col_reg < COL_MAX) begin
                col_reg <= col_reg + CW'(1);
              end
            end
          end else begin
            phase_reg <= 1'b0;
          end

          if (href_fall) begin
            line_err_reg <= err_after_line;
            col_reg      <= '0;
            row_reg      <= row_after_line;
            if (row_reg < ROW_MAX) begin
              row_base_reg <= row_base_reg + LINE_STEP;
            end
          end

          if (vs_rise) begin
            frame_done_reg <= 1'b1;
            frame_ok_reg   <= (row_at_end == ROW_MAX) & ~err_at_end;
            if (bus.capture_en) begin
              state_reg <= SYNC;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.frame_we    = frame_we_reg;
  assign bus.frame_addr  = frame_addr_reg;
  assign bus.frame_wdata = frame_wdata_reg;
  assign bus.frame_done  = frame_done_reg;
  assign bus.frame_ok    = frame_ok_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: doc/cam_frame_writer.md
Name: cam_frame_writer

Overview:
- Camera-side writer for the 320x240 RGB444 frame buffer that the VGA display path reads.
- Samples an OV7670-style parallel pixel stream (VSYNC/HREF/8-bit data, RGB565, high byte first) and converts each pixel to 12-bit RGB444.
- Issues one buffer write per pixel at linear address row*H_ACTIVE+col.
- Frames start on VSYNC falling edge and end on VSYNC rising edge, and are gated by a capture enable.

Parameters:
- H_ACTIVE, 320, pixels written per line.
- V_ACTIVE, 240, lines written per frame.
- ADDR_W, 17, frame address width; must satisfy H_ACTIVE*V_ACTIVE <= 2^ADDR_W.

Ports:
- clk  in  1  pixel clock; cam_* inputs are synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- capture_en  in  1  level; 1 = capture frames continuously.
- cam_vsync  in  1  frame sync; high = vertical blanking.
- cam_href  in  1  high while the line's data bytes are valid.
- cam_data  in  8  pixel byte.
- frame_we  out  1  one-cycle buffer write strobe.
- frame_addr  out  ADDR_W  write address.
- frame_wdata  out  12  {R[3:0],G[3:0],B[3:0]}.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- frame_ok  out  1  status of the last completed frame; valid from frame_done onward.
- busy  out  1  high in SYNC or ACTIVE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; frame_we, frame_addr, frame_wdata, frame_done, frame_ok, busy = 0.
  - Internal vsync_q, href_q, byte phase, col, row, row_base, line_err all 0.
  - Reset asserted mid-frame aborts the frame immediately with no further writes.
- Edge detection on registered copies: vs_fall = vsync_q & ~cam_vsync; vs_rise = ~vsync_q & cam_vsync; href_fall = href_q & ~cam_href. vsync_q resets to 0, so a low VSYNC at reset release is not treated as a frame start.
- State machine:
  - IDLE: capture_en=1 -> SYNC.
  - SYNC: waits for vs_fall.
    - vs_fall -> ACTIVE; clear col, row, row_base, line_err, byte phase.
    - capture_en=0 -> IDLE.
  - ACTIVE, on vs_rise:
    - Pulse frame_done for one cycle.
    - frame_ok <= (row==V_ACTIVE) & ~line_err.
    - Next state is SYNC if capture_en=1, else IDLE.
    - Deasserting capture_en mid-frame does not truncate the frame.
- A frame already in progress when capture_en rises is skipped entirely; capture begins at the next vs_fall.
- Byte pairing in ACTIVE, while cam_href=1:
  - Phase 0: latch the high byte, set phase=1.
  - Phase 1: form the pixel and clear phase.
  - Phase is forced to 0 whenever cam_href=0, so an odd trailing byte is dropped.
- Conversion, with hi=byte0 and lo=byte1:
  - R = hi[7:4]
  - G = {hi[2:0],lo[7]}
  - B = lo[4:1]
- Write: on each phase-1 cycle with col<H_ACTIVE and row<V_ACTIVE, the next cycle has frame_we=1, frame_addr=row_base+col, frame_wdata=converted pixel. Latency is 1 clk from the second byte. col increments on every completed pixel and saturates at H_ACTIVE.
- Pixels with col>=H_ACTIVE or row>=V_ACTIVE are discarded (no write), so an overrun can never address beyond H_ACTIVE*V_ACTIVE-1.
- On href_fall in ACTIVE:
  - If col != H_ACTIVE, set line_err.
  - Then col=0, row+=1 (saturating at V_ACTIVE), and row_base+=H_ACTIVE while row<V_ACTIVE.
- Simultaneous vs_rise and href_fall: the line end is processed first, then the frame end is evaluated with the updated row.
- frame_addr and frame_wdata hold their last values when frame_we=0.
- busy = (state != IDLE), registered.

Test Plan:
- Reset values: hold rst_n=0 with random cam inputs -> all outputs 0, no frame_we. Release with cam_vsync=0 -> no capture until a real vs_fall.
- Colour packing: bytes 0xF8,0x00 / 0x07,0xE0 / 0x00,0x1F as pixels 0..2 of line 0 -> writes (addr 0, 0xF00), (1, 0x0F0), (2, 0x00F), each one clk after the second byte.
- Full frame: 240 lines x 320 pixels with incrementing data -> exactly 76800 writes at addrs 0..76799 in order; frame_done pulses once; frame_ok=1.
- Overrun/underrun:
  - Line 5 carries 322 pixels -> only 320 writes, last at addr 1919; frame_ok=0.
  - A frame with 239 lines -> frame_ok=0.
- Enable timing:
  - capture_en rises mid-frame -> zero writes until the next vs_fall.
  - capture_en falls on line 100 -> frame completes to addr 76799, frame_done, then IDLE (busy=0) and no further writes.
- Async reset at line 50 -> outputs 0 immediately. After release with capture_en=1, the next frame restarts at addr 0.
